// File: rtl/dram_arb_pkg.sv
// Shared constants and helpers for the LUT-RAM port arbiter.
package dram_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_DATA_WIDTH = 1;
  localparam int MAX_N_REQ          = 4;
  localparam int IDX_W              = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  // Converts a one-hot grant (up to MAX_N_REQ bits) into a requester index.
  function automatic req_idx_t onehot_to_index(input logic [MAX_N_REQ-1:0] onehot);
    req_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_N_REQ; i++) begin
      if (onehot[i]) idx = req_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward (wrapping) and grants the
// first requester found; ptr then moves just past the winner.
module rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  req_idx_t ptr;
  req_idx_t grant_idx;
  logic     found;

  // Pick the first active request at or after ptr, wrapping modulo N.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + k) % N))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign grant_idx = onehot_to_index(MAX_N_REQ'(grant));

  // Advance the pointer past the winner; hold it when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == req_idx_t'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one dual-port LUT RAM between N_REQ requesters: one write and one
// read may be issued per cycle, each class with its own round-robin arbiter.
// Memory-side signals are registered; read data returns two cycles after
// acceptance as a one-cycle pulse to the requester that issued the read.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic [ADDR_WIDTH-1:0]       mem_write_address,
  output logic [DATA_WIDTH-1:0]       mem_write_data,
  output logic                        mem_write_enable,
  output logic [ADDR_WIDTH-1:0]       mem_read_address,
  input  logic [DATA_WIDTH-1:0]       mem_read_data
);

  logic [N_REQ-1:0]      wr_req;
  logic [N_REQ-1:0]      rd_req;
  logic [N_REQ-1:0]      wr_grant;
  logic [N_REQ-1:0]      rd_grant;
  logic [N_REQ-1:0]      rd_owner;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;

  // Split requests into write and read candidates; nothing competes during reset
  // so req_ready stays low while rst is high.
  always_comb begin
    wr_req = req_valid &  req_write & {N_REQ{~rst}};
    rd_req = req_valid & ~req_write & {N_REQ{~rst}};
  end

  rr_arbiter #(.N(N_REQ)) u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (wr_req),
    .grant (wr_grant)
  );

  rr_arbiter #(.N(N_REQ)) u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (rd_req),
    .grant (rd_grant)
  );

  assign req_ready = wr_grant | rd_grant;

  // Select the granted requester's address and data slices for each port.
  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    rd_addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wr_grant[i]) begin
        wr_addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_sel = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_grant[i]) begin
        rd_addr_sel = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Register memory-side signals and run the two-stage read response pipeline;
  // the RAM output is sampled at the end of the read's memory cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write_enable  <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_read_address  <= '0;
      rd_owner          <= '0;
      rsp_valid         <= '0;
      rsp_data          <= '0;
    end else begin
      mem_write_enable <= |wr_grant;
      if (|wr_grant) begin
        mem_write_address <= wr_addr_sel;
        mem_write_data    <= wr_data_sel;
      end
      if (|rd_grant) begin
        mem_read_address <= rd_addr_sel;
      end
      rd_owner  <= rd_grant;
      rsp_valid <= rd_owner;
      if (|rd_owner) begin
        rsp_data <= mem_read_data;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed scoreboard bench for dram_port_arbiter with a behavioural LUT RAM
// whose initial contents are the XOR of each address's bits.
module tb_dram_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 1;

  typedef struct {
    logic [N-1:0] owner;
    logic         data;
    int           due;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_enable;
  logic [AW-1:0]   mem_read_address;
  logic [DW-1:0]   mem_read_data;

  logic [DW-1:0] ram [0:63];
  exp_t          expq[$];
  int            cyc = 0;
  int            compared = 0;
  int            mismatched = 0;

  dram_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so responses can be checked against their due cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents start as the parity of each address.
  initial begin
    for (int a = 0; a < 64; a++) begin
      logic [5:0] av;
      av = a[5:0];
      ram[a] <= ^av;
    end
  end

  // Synchronous write port of the LUT RAM.
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_write_address] <= mem_write_data;
  end

  assign mem_read_data = ram[mem_read_address];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int i, input bit v, input bit w, input int a, input bit d);
    req_valid[i]         = v;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a[AW-1:0];
    req_wdata[i]         = d;
  endtask

  task automatic expectRead(input logic [N-1:0] owner, input logic data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    e.due   = cyc + 2;
    expq.push_back(e);
  endtask

  task automatic cycleCheck(input string name, input logic [N-1:0] want);
    @(negedge clk);
    checkOutput(name, int'(req_ready), int'(want));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      cycleCheck("idle_ready", 2'b00);
      nextCycle();
    end
  endtask

  task automatic clearReqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Monitor: every response pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid != '0) begin
      if (expq.size() == 0) begin
        checkOutput("rsp_unexpected", int'(rsp_valid), 0);
      end else begin
        e = expq.pop_front();
        checkOutput("rsp_cycle", cyc, e.due);
        checkOutput("rsp_owner", int'(rsp_valid), int'(e.owner));
        checkOutput("rsp_data", int'(rsp_data), int'(e.data));
      end
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      e = expq.pop_front();
      checkOutput("rsp_missing", int'(rsp_valid), int'(e.owner));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    logic [N-1:0] s3_want [4];
    s3_want = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1;
    clearReqs();
    nextCycle();
    nextCycle();

    // Reset state, with requests present to show ready is held low.
    applyStimulus(0, 1, 0, 9, 0);
    applyStimulus(1, 1, 1, 9, 1);
    cycleCheck("rst_ready", 2'b00);
    checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
    checkOutput("rst_rsp_data", int'(rsp_data), 0);
    checkOutput("rst_we", int'(mem_write_enable), 0);
    checkOutput("rst_waddr", int'(mem_write_address), 0);
    checkOutput("rst_wdata", int'(mem_write_data), 0);
    checkOutput("rst_raddr", int'(mem_read_address), 0);
    nextCycle();
    clearReqs();
    rst = 1'b0;

    // Single read of addr 7 by req0 in the first cycle after reset.
    applyStimulus(0, 1, 0, 7, 0);
    expectRead(2'b01, 1'b1);
    cycleCheck("s1_ready", 2'b01);
    nextCycle();
    clearReqs();
    cycleCheck("s1_idle", 2'b00);
    checkOutput("s1_raddr", int'(mem_read_address), 7);
    nextCycle();
    idleCycles(3);

    // Write addr 5 = 1, then read it back the next cycle.
    applyStimulus(0, 1, 1, 5, 1);
    cycleCheck("s2_wr_ready", 2'b01);
    nextCycle();
    applyStimulus(0, 1, 0, 5, 0);
    expectRead(2'b01, 1'b1);
    cycleCheck("s2_rd_ready", 2'b01);
    checkOutput("s2_we", int'(mem_write_enable), 1);
    checkOutput("s2_waddr", int'(mem_write_address), 5);
    checkOutput("s2_wdata", int'(mem_write_data), 1);
    nextCycle();
    clearReqs();
    cycleCheck("s2_idle", 2'b00);
    checkOutput("s2_we_drop", int'(mem_write_enable), 0);
    nextCycle();
    idleCycles(3);

    // Both requesters write continuously after a reset: grants alternate.
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 1, 1, 20, 0);
    applyStimulus(1, 1, 1, 21, 1);
    for (int k = 0; k < 4; k++) begin
      cycleCheck("s3_ready", s3_want[k]);
      if (k > 0) begin
        checkOutput("s3_we", int'(mem_write_enable), 1);
        checkOutput("s3_waddr", int'(mem_write_address), (k % 2 == 1) ? 20 : 21);
      end
      nextCycle();
    end
    clearReqs();
    cycleCheck("s3_tail", 2'b00);
    checkOutput("s3_we_last", int'(mem_write_enable), 1);
    checkOutput("s3_waddr_last", int'(mem_write_address), 21);
    nextCycle();
    cycleCheck("s3_tail2", 2'b00);
    checkOutput("s3_we_off", int'(mem_write_enable), 0);
    nextCycle();

    // Same-cycle write and read of addr 3: read sees the old value.
    applyStimulus(0, 1, 1, 3, 1);
    applyStimulus(1, 1, 0, 3, 0);
    expectRead(2'b10, 1'b0);
    cycleCheck("s4_ready", 2'b11);
    nextCycle();
    clearReqs();
    idleCycles(3);
    applyStimulus(0, 1, 0, 3, 0);
    expectRead(2'b01, 1'b1);
    cycleCheck("s4_reread", 2'b01);
    nextCycle();
    clearReqs();
    idleCycles(3);

    // Read by req1 accepted, then reset before its response is due.
    applyStimulus(1, 1, 0, 7, 0);
    cycleCheck("s5_ready", 2'b10);
    nextCycle();
    rst = 1'b1;
    cycleCheck("s5_rst_ready", 2'b00);
    nextCycle();
    cycleCheck("s5_rst_ready2", 2'b00);
    checkOutput("s5_rsp_valid", int'(rsp_valid), 0);
    checkOutput("s5_rsp_data", int'(rsp_data), 0);
    checkOutput("s5_we", int'(mem_write_enable), 0);
    checkOutput("s5_waddr", int'(mem_write_address), 0);
    checkOutput("s5_wdata", int'(mem_write_data), 0);
    checkOutput("s5_raddr", int'(mem_read_address), 0);
    nextCycle();
    rst = 1'b0;
    expectRead(2'b10, 1'b1);
    cycleCheck("s5_post_ready", 2'b10);
    nextCycle();
    clearReqs();
    idleCycles(3);

    // Both requesters read continuously: alternating one-hot responses.
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 2, 0);
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] owner;
      owner = (k % 2 == 0) ? 2'b01 : 2'b10;
      expectRead(owner, 1'b1);
      cycleCheck("s6_ready", owner);
      nextCycle();
    end
    clearReqs();
    idleCycles(4);

    checkOutput("scoreboard_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
